l_fifo_prefetch_ctl: RTL

//  Parametrised synchronous first-word-fall-through (prefetch) FIFO, successor to the

---
 rtl/l_fifo_prefetch_ctl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/l_fifo_prefetch_ctl.sv
// ---------------------------------------------------------------------------
// l_fifo_prefetch_ctl
// Parametrised single-clock first-word-fall-through FIFO. A synchronous RAM
// feeds a two-register prefetch pipeline (stage -> output) so the head word
// is always presented on rd_data, and a pop is followed by the next word with
// no bubble. The design tracks the fill level, programmable almost-full and
// almost-empty thresholds, a synchronous flush, and sticky overflow and
// underflow flags.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-low (has priority over flush)
//   flush         synchronous clear of contents and error flags
//   wr_en/wr_data write request and data; the write is accepted when wr_vld=1
//   wr_vld        FIFO not full (registered)
//   rd_en         pop request; the pop happens when rd_vld=1
//   rd_data       head word, valid while rd_vld=1
//   rd_vld        head word present
//   level         words held (RAM + prefetch stage + output register)
//   almost_full   level >= AF_THRESH
//   almost_empty  level <= AE_THRESH
//   overflow      sticky: wr_en while wr_vld=0
//   underflow     sticky: rd_en while rd_vld=0
// ---------------------------------------------------------------------------
module l_fifo_prefetch_ctl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned AF_THRESH = 2040,
    parameter int unsigned AE_THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_vld,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  ram_cnt;
    logic              stage_vld_q, stage_vld_d;
    logic [DATA_W-1:0] stage_data_q;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              wr_vld_q, wr_vld_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic wr_acc;
    logic pop;
    logic advance;
    logic fetch;

    // Handshake qualifiers; flush suppresses every transfer in its cycle
    always_comb begin
        ram_cnt = level_q - LVL_W'(out_vld_q) - LVL_W'(stage_vld_q);
        wr_acc  = wr_en & wr_vld_q & ~flush & rst;
        pop     = rd_en & out_vld_q & ~flush;
        // stage moves into the output register when that register is free or being popped
        advance = stage_vld_q & (~out_vld_q | pop);
        // only words written on an earlier edge are fetched, so RAM read never races a write
        fetch   = (ram_cnt != '0) & (~stage_vld_q | advance) & ~flush & rst;
    end

    // Next-state for pointers, prefetch pipeline, level and flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        stage_vld_d = stage_vld_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            stage_vld_d = 1'b0;
            out_vld_d   = 1'b0;
            out_data_d  = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (fetch) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            stage_vld_d = fetch | (stage_vld_q & ~advance);
            if (advance) begin
                out_vld_d  = 1'b1;
                out_data_d = stage_data_q;
            end else if (pop) begin
                out_vld_d  = 1'b0;
            end
            level_d = level_q + LVL_W'(wr_acc) - LVL_W'(pop);
            ovf_d   = ovf_q | (wr_en & ~wr_vld_q);
            unf_d   = unf_q | (rd_en & ~out_vld_q);
        end

        wr_vld_d = (level_d < LVL_W'(DEPTH));
        af_d     = (level_d >= LVL_W'(AF_THRESH));
        ae_d     = (level_d <= LVL_W'(AE_THRESH));
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            stage_vld_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            wr_vld_q    <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            stage_vld_q <= stage_vld_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            wr_vld_q    <= wr_vld_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage array and synchronous read into the prefetch stage (never reset)
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (fetch) begin
            stage_data_q <= mem[rd_ptr_q];
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_data      = out_data_q;
    assign rd_vld       = out_vld_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
